mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multi-cycle control sequencer for the MIPS datapath (IF/ID/EX/MA blocks, register file, shared memory). Decodes the latched instruction opcode/funct and steps a Moore state machine through fetch, decode, execute, memory and write-back, driving every datapath enable and mux select for one instruction at a time. Also owns the instruction-load window: while the external loader holds `WE`, the CPU is parked and no architectural state is written.

## Interface
Parameters:
- `HALT_OP`, 6'b111111, opcode that parks the sequencer in HALT

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset; asynchronous, active-low
- `WE`  in  1  external instruction-load request
- `Op`  in  6  opcode, Ins[31:26] from instruction register
- `Funct`  in  6  Ins[5:0]
- `Zero`  in  1  ALU zero flag from EX
- `PCWrite`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`  out  1 each  datapath write/read enables
- `IorD`  out  1  memory address: 0 = PC, 1 = ALU result register
- `RegDst`  out  1  0 = rt, 1 = rd; forced 1 with `Op`=000011 path writing r31 via `Link`
- `Link`  out  1  write-back targets r31 with nextPC (jal)
- `MemtoReg`  out  1  write-back source: 0 = ALU result, 1 = memory data
- `ALUSrcA`  out  1  0 = PC, 1 = Rdata1
- `ALUSrcB`  out  2  00 Rdata2, 01 constant 4, 10 Ed32, 11 Ed32<<2
- `ALUOp`  out  2  00 add, 01 subtract, 10 use Funct, 11 use Op (immediate logic)
- `PCSrc`  out  2  00 ALU output, 01 ALU result register (branch target), 10 jump target
- `State`  out  4  current state code
- `Busy`  out  1  high in every state except LOAD and HALT

## Operation
- States (code): LOAD 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ADDR 5, MEM_RD 6, MEM_WR 7, WB 8, BRANCH 9, JUMP 10, HALT 11.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precomputed). Next by `Op`: 000000 -> EXEC_R; 001000/001100/001101 -> EXEC_I; 100011/101011 -> ADDR; 000100/000101 -> BRANCH; 000010/000011 -> JUMP; `HALT_OP` -> HALT; any other -> FETCH (NOP).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB (RegDst=1, MemtoReg=0). Funct 001000 (jr) instead: PCSrc=00 with ALUSrcA=1, ALUSrcB=00, ALUOp=00 add-zero path not used; jr sets PCWrite=1, PCSrc=10 selecting Rdata1 -> FETCH, no WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB (RegDst=0, MemtoReg=0).
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1 -> WB (RegDst=0, MemtoReg=1).
- MEM_WR: MemWrite=1, IorD=1 -> FETCH.
- WB: RegWrite=1 for exactly this cycle -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01; PCWrite = `Zero` for beq, `~Zero` for bne -> FETCH.
- JUMP: PCSrc=10, PCWrite=1; jal also RegWrite=1, Link=1 -> FETCH.
- HALT: all enables 0; left only by reset or `WE`.
- All outputs not listed for a state are 0.

## Timing
- Reset (RST=0): State=LOAD immediately, all enables 0, selects 0, Busy=0.
- LOAD: stays while `WE`=1; first edge with `WE`=0 -> FETCH.
- `WE`=1 sampled in any state forces LOAD at the next edge; the in-flight instruction is abandoned and the current-state enables still apply that cycle (loader must raise `WE` only between instructions or accept the abort).
- Cycles per instruction: R/I-type 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3, NOP 2.
- Outputs are pure functions of `State` plus `Op`/`Funct`/`Zero`; no output depends on `WE` combinationally.
- Reset asserted mid-instruction: no further enables after RST falls.

## Configuration
- `MC_PERF_COUNT_EN` defined: adds outputs `CycleCnt` [31:0] (increments each cycle Busy=1) and `InstCnt` [31:0] (increments on each return to FETCH from a non-LOAD state); both clear on reset and on LOAD entry, wrap at 2^32.
- Not defined: ports absent, no counter logic.

## Test plan
- Reset, `WE`=1 three cycles then 0 -> State 0,0,0 then 1 on the edge after `WE` falls; no PCWrite/RegWrite during LOAD.
- `Op`=000000, `Funct`=100000 -> State 1,2,3,8,1; RegWrite=1 only in state 8 with RegDst=1.
- `Op`=100011 -> states 1,2,5,6,8,1; MemtoReg=1, IorD=1 in 6; 5 cycles total.
- `Op`=000100 with `Zero`=1 then `Zero`=0 -> PCWrite=1 in BRANCH first case, 0 second; both return to FETCH after 3 cycles.
- `Op`=111111 -> HALT holds 10 cycles with Busy=0; `WE` pulse -> LOAD -> FETCH.
- With `MC_PERF_COUNT_EN`: run two R-type instructions from LOAD -> InstCnt=2, CycleCnt=8.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving datapath enables/selects, with external instruction-load window.
// Optional MC_PERF_COUNT_EN adds CycleCnt/InstCnt performance counters.
module mips_mc_control #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WE,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       Link,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       Busy
`ifdef MC_PERF_COUNT_EN
  ,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstCnt
`endif
);

  typedef enum logic [3:0] {
    S_LOAD   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB     = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state, next_state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_LOAD;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:                 next_state = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_EXEC_I;
          OP_LW, OP_SW:             next_state = S_ADDR;
          OP_BEQ, OP_BNE:           next_state = S_BRANCH;
          OP_J, OP_JAL:             next_state = S_JUMP;
          default:                  next_state = (Op == HALT_OP) ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R: next_state = (Funct == FN_JR) ? S_FETCH : S_WB;
      S_EXEC_I: next_state = S_WB;
      S_ADDR:   next_state = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: next_state = S_WB;
      S_MEM_WR: next_state = S_FETCH;
      S_WB:     next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_LOAD;
    endcase
    // A load request overrides whatever instruction is in flight.
    if (WE) next_state = S_LOAD;
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    Link     = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    Busy     = (state != S_LOAD) && (state != S_HALT);
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        if (Funct == FN_JR) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end else begin
          ALUOp  = 2'b10;
          RegDst = 1'b1;
        end
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (Op == OP_RTYPE);
        MemtoReg = (Op == OP_LW);
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCWrite = (Op == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        if (Op == OP_JAL) begin
          RegWrite = 1'b1;
          Link     = 1'b1;
          RegDst   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign State = state;

`ifdef MC_PERF_COUNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CycleCnt <= '0;
      InstCnt  <= '0;
    end else if (next_state == S_LOAD) begin
      CycleCnt <= '0;
      InstCnt  <= '0;
    end else begin
      if (Busy) CycleCnt <= CycleCnt + 32'd1;
      if (state != S_LOAD && next_state == S_FETCH) InstCnt <= InstCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed and random instructions checked against an instruction-level model.
module tb_mips_mc_control;

  logic       CLK, RST, WE, Zero;
  logic [5:0] Op, Funct;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, Link, MemtoReg, ALUSrcA, Busy;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] CycleCnt, InstCnt;
`endif

  int n_assert = 0;
  int n_fail = 0;

  mips_mc_control #(.HALT_OP(6'b111111)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .RegDst(RegDst), .Link(Link), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .State(State), .Busy(Busy)
`ifdef MC_PERF_COUNT_EN
    , .CycleCnt(CycleCnt), .InstCnt(InstCnt)
`endif
  );

  logic [16:0] outs;
  assign outs = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, RegDst, Link,
                 MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Busy};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  typedef int seq_t[$];

  // Instruction-level model: the state walk each instruction class takes from FETCH.
  function automatic seq_t exp_seq(input logic [5:0] op, input logic [5:0] fn);
    seq_t q;
    case (op)
      6'b000000:                     if (fn == 6'b001000) q = {1, 2, 3}; else q = {1, 2, 3, 8};
      6'b001000, 6'b001100, 6'b001101: q = {1, 2, 4, 8};
      6'b100011:                     q = {1, 2, 5, 6, 8};
      6'b101011:                     q = {1, 2, 5, 7};
      6'b000100, 6'b000101:          q = {1, 2, 9};
      6'b000010, 6'b000011:          q = {1, 2, 10};
      6'b111111:                     q = {1, 2, 11};
      default:                       q = {1, 2};
    endcase
    return q;
  endfunction

  // Expected control word for a state while executing the given instruction.
  function automatic logic [16:0] exp_out(input int s, input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic pcw, irw, rw, mr, mw, iord, rd, lnk, m2r, sa, busy;
    logic [1:0] sb, aop, pcs;
    {pcw, irw, rw, mr, mw, iord, rd, lnk, m2r, sa} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    busy = (s != 0) && (s != 11);
    case (s)
      1:  begin mr = 1; irw = 1; pcw = 1; sb = 2'b01; end
      2:  sb = 2'b11;
      3:  begin
            sa = 1;
            if (fn == 6'b001000) begin pcw = 1; pcs = 2'b10; end
            else begin aop = 2'b10; rd = 1; end
          end
      4:  begin sa = 1; sb = 2'b10; aop = 2'b11; end
      5:  begin sa = 1; sb = 2'b10; end
      6:  begin mr = 1; iord = 1; m2r = 1; end
      7:  begin mw = 1; iord = 1; end
      8:  begin rw = 1; rd = (op == 6'b000000); m2r = (op == 6'b100011); end
      9:  begin sa = 1; aop = 2'b01; pcs = 2'b01; pcw = (op == 6'b000101) ? !z : z; end
      10: begin pcs = 2'b10; pcw = 1; if (op == 6'b000011) begin rw = 1; lnk = 1; rd = 1; end end
      default: ;
    endcase
    return {pcw, irw, rw, mr, mw, iord, rd, lnk, m2r, sa, sb, aop, pcs, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1 with State == FETCH; leaves at negedge+1 in FETCH (or HALT).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm);
    seq_t seq;
    Op = op; Funct = fn; Zero = z;
    #1;
    seq = exp_seq(op, fn);
    foreach (seq[i]) begin
      if (i > 0) begin @(negedge CLK); #1; end
      check($sformatf("%s state[%0d]", nm, i), 32'(State), 32'(seq[i]));
      check($sformatf("%s ctrl[%0d]", nm, i), 32'(outs), 32'(exp_out(seq[i], op, fn, z)));
    end
    if (seq[seq.size()-1] != 11) begin
      @(negedge CLK); #1;
      check($sformatf("%s return", nm), 32'(State), 32'd1);
    end
  endtask

  logic [5:0] op_tab [14] = '{6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011, 6'b101011,
                              6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b000001, 6'b010000, 6'b110001};

  initial begin
    logic [5:0] rop, rfn;
    int idx;
    RST = 1'b0; WE = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
    #3;
    check("reset state", 32'(State), 32'd0);
    check("reset ctrl", 32'(outs), 32'd0);

    @(negedge CLK); RST = 1'b1; WE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      check($sformatf("load hold state %0d", i), 32'(State), 32'd0);
      check($sformatf("load hold ctrl %0d", i), 32'(outs), 32'd0);
    end
    WE = 1'b0;
    @(negedge CLK); #1;
    check("load exit", 32'(State), 32'd1);

    run_instr(6'b000000, 6'b100000, 1'b0, "add");
    run_instr(6'b000000, 6'b100010, 1'b1, "sub");
`ifdef MC_PERF_COUNT_EN
    check("perf inst", InstCnt, 32'd2);
    check("perf cycle", CycleCnt, 32'd8);
`endif
    run_instr(6'b100011, 6'b000000, 1'b0, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, "sw");
    run_instr(6'b000100, 6'b000000, 1'b1, "beq taken");
    run_instr(6'b000100, 6'b000000, 1'b0, "beq not taken");
    run_instr(6'b000101, 6'b000000, 1'b0, "bne taken");
    run_instr(6'b000101, 6'b000000, 1'b1, "bne not taken");
    run_instr(6'b001101, 6'b000000, 1'b0, "ori");
    run_instr(6'b000010, 6'b000000, 1'b0, "j");
    run_instr(6'b000011, 6'b000000, 1'b0, "jal");
    run_instr(6'b000000, 6'b001000, 1'b0, "jr");
    run_instr(6'b011100, 6'b000000, 1'b0, "nop");

    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 15);
      if (idx < 14) rop = op_tab[idx];
      else begin
        rop = 6'($urandom);
        if (rop == 6'b111111) rop = 6'b010001;
      end
      rfn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(rop, rfn, 1'($urandom), $sformatf("rand%0d op%0h", k, rop));
    end

    // Load request mid-instruction: current-state controls still apply, then LOAD.
    Op = 6'b100011; Funct = '0; Zero = 1'b0;
    @(negedge CLK); @(negedge CLK); #1;
    WE = 1'b1; #1;
    check("abort state", 32'(State), 32'd5);
    check("abort ctrl", 32'(outs), 32'(exp_out(5, 6'b100011, 6'b0, 1'b0)));
    @(negedge CLK); #1;
    check("abort to load", 32'(State), 32'd0);
    WE = 1'b0;
    @(negedge CLK); #1;
    check("abort refetch", 32'(State), 32'd1);

    // Asynchronous reset in the middle of an instruction.
    Op = 6'b000000; Funct = 6'b100000;
    @(negedge CLK); @(negedge CLK); #1;
    check("pre-reset state", 32'(State), 32'd3);
    RST = 1'b0; #1;
    check("async reset state", 32'(State), 32'd0);
    check("async reset ctrl", 32'(outs), 32'd0);
    @(negedge CLK); RST = 1'b1; #1;
    @(negedge CLK); #1;
    check("post-reset fetch", 32'(State), 32'd1);

    run_instr(6'b111111, 6'b000000, 1'b0, "halt");
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      check($sformatf("halt hold %0d", i), 32'(State), 32'd11);
      check($sformatf("halt ctrl %0d", i), 32'(outs), 32'd0);
    end
    WE = 1'b1;
    @(negedge CLK); #1;
    check("halt to load", 32'(State), 32'd0);
    WE = 1'b0;
    @(negedge CLK); #1;
    check("halt refetch", 32'(State), 32'd1);
    run_instr(6'b000000, 6'b100101, 1'b0, "or after halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
